// File: rtl/serial_bit_assembler.sv
// Serial-to-parallel word assembler with LSB/MSB-first placement, early
// frame termination with zero-fill, and two words of output buffering.
module serial_bit_assembler #(
    parameter int  WIDTH     = 8,
    parameter int  MSB_FIRST = 0,
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_count,
    output logic             out_short
);

    typedef enum logic {
        ASSEMBLE = 1'b0,
        FULL     = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     hold_cnt_q, hold_cnt_d;
    logic              hold_short_q, hold_short_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [CW-1:0]     out_count_q, out_count_d;
    logic              out_short_q, out_short_d;
    logic              out_valid_q, out_valid_d;

    logic              accept;
    logic              out_hs;
    logic              slot_free;
    logic              at_top;
    logic              done;
    logic [CW-1:0]     pos;
    logic [WIDTH-1:0]  word;
    logic [CW-1:0]     word_cnt;
    logic              word_short;

    // in_ready depends only on registered state and rst, never on out_ready
    assign in_ready  = (state_q == ASSEMBLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_short = out_short_q;

    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;
    assign slot_free = !out_valid_q || out_ready;
    assign at_top    = (cnt_q == CW'(WIDTH - 1));
    assign done      = accept && (at_top || in_last);

    // A is kept zero between words, so unwritten positions stay zero-filled
    assign pos        = (MSB_FIRST != 0) ? (CW'(WIDTH - 1) - cnt_q) : cnt_q;
    assign word       = a_q | ({{(WIDTH-1){1'b0}}, in_bit} << pos);
    assign word_cnt   = cnt_q + CW'(1);
    assign word_short = in_last && !at_top;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        cnt_d        = cnt_q;
        hold_cnt_d   = hold_cnt_q;
        hold_short_d = hold_short_q;
        out_data_d   = out_data_q;
        out_count_d  = out_count_q;
        out_short_d  = out_short_q;
        out_valid_d  = out_valid_q && !out_hs;

        unique case (state_q)
            ASSEMBLE: begin
                if (accept) begin
                    if (done) begin
                        cnt_d = '0;
                        if (slot_free) begin
                            out_data_d  = word;
                            out_count_d = word_cnt;
                            out_short_d = word_short;
                            out_valid_d = 1'b1;
                            a_d         = '0;
                        end else begin
                            a_d          = word;
                            hold_cnt_d   = word_cnt;
                            hold_short_d = word_short;
                            state_d      = FULL;
                        end
                    end else begin
                        a_d   = word;
                        cnt_d = word_cnt;
                    end
                end
            end
            FULL: begin
                if (out_hs) begin
                    out_data_d  = a_q;
                    out_count_d = hold_cnt_q;
                    out_short_d = hold_short_q;
                    out_valid_d = 1'b1;
                    a_d         = '0;
                    state_d     = ASSEMBLE;
                end
            end
            default: state_d = ASSEMBLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ASSEMBLE;
            a_q          <= '0;
            cnt_q        <= '0;
            hold_cnt_q   <= '0;
            hold_short_q <= 1'b0;
            out_data_q   <= '0;
            out_count_q  <= '0;
            out_short_q  <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            cnt_q        <= cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            hold_short_q <= hold_short_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            out_short_q  <= out_short_d;
            out_valid_q  <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_serial_bit_assembler.sv
// Bench for serial_bit_assembler: LSB-first and MSB-first instances share
// stimulus and are checked against a word-queue reference model.
module tb_serial_bit_assembler;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_bit;
    logic          in_last;
    logic          out_ready;
    logic          rdy0, rdy1;
    logic          ov0, ov1;
    logic [W-1:0]  d0, d1;
    logic [CW-1:0] c0, c1;
    logic          s0, s1;

    always #5 clk = ~clk;

    serial_bit_assembler #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy0),
        .in_bit(in_bit), .in_last(in_last),
        .out_valid(ov0), .out_ready(out_ready),
        .out_data(d0), .out_count(c0), .out_short(s0)
    );

    serial_bit_assembler #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy1),
        .in_bit(in_bit), .in_last(in_last),
        .out_valid(ov1), .out_ready(out_ready),
        .out_data(d1), .out_count(c1), .out_short(s1)
    );

    typedef struct {
        int lsb;
        int msb;
        int cnt;
        int sh;
    } word_t;

    word_t exp_q[$];
    int    part_q[$];
    int    vpos[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // One clock: check outputs at negedge, advance the model at posedge
    task automatic step();
        bit    acc, hs;
        int    pend;
        word_t w;
        @(negedge clk);
        cyc++;
        pend = exp_q.size();
        chk("in_ready_lsb", rdy0, 32'(!rst && pend < 2));
        chk("in_ready_msb", rdy1, 32'(!rst && pend < 2));
        chk("out_valid_lsb", ov0, 32'(pend > 0));
        chk("out_valid_msb", ov1, 32'(pend > 0));
        if (pend > 0) begin
            chk("data_lsb", d0, exp_q[0].lsb);
            chk("data_msb", d1, exp_q[0].msb);
            chk("count_lsb", c0, exp_q[0].cnt);
            chk("count_msb", c1, exp_q[0].cnt);
            chk("short_lsb", s0, exp_q[0].sh);
            chk("short_msb", s1, exp_q[0].sh);
        end
        if (ov0 === 1'b1) vpos.push_back(cyc);
        acc = in_valid && !rst && pend < 2;
        hs  = out_ready && pend > 0;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            part_q.delete();
        end else begin
            if (hs) void'(exp_q.pop_front());
            if (acc) begin
                part_q.push_back(int'(in_bit));
                if (part_q.size() == W || in_last) begin
                    w.lsb = 0;
                    w.msb = 0;
                    foreach (part_q[k]) begin
                        w.lsb += part_q[k] << k;
                        w.msb += part_q[k] << (W - 1 - k);
                    end
                    w.cnt = part_q.size();
                    w.sh  = int'(in_last && part_q.size() < W);
                    exp_q.push_back(w);
                    part_q.delete();
                end
            end
        end
        #1;
    endtask

    task automatic send(input int b, input int last);
        in_valid = 1'b1;
        in_bit   = b[0];
        in_last  = last[0];
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send(int'(v[i]), 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", ov0, 0);
        chk("rst_data", d0, 0);
        chk("rst_count", c0, 0);
        chk("rst_short", s0, 0);
        idle();

        // full word, both bit orders
        send(1, 0); send(0, 0); send(1, 0); send(1, 0);
        send(0, 0); send(0, 0); send(1, 0); send(0, 0);
        chk("full_lsb", d0, 8'h4D);
        chk("full_msb", d1, 8'hB2);
        chk("full_count", c0, 8);
        chk("full_short", s0, 0);
        chk("full_valid", ov0, 1);
        idle();
        chk("full_one_cycle", ov0, 0);

        // short frame then independent full word
        send(1, 0); send(1, 0); send(1, 1);
        chk("short_lsb", d0, 8'h07);
        chk("short_msb", d1, 8'hE0);
        chk("short_count", c0, 3);
        chk("short_flag", s0, 1);
        chk("short_flag_msb", s1, 1);
        for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 1)), 0);
        idle();
        idle();

        // backpressure: two words buffered, input stalls
        out_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h3C);
        chk("bp_ready_low", rdy0, 0);
        chk("bp_hold_data", d0, 8'hA5);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        step();
        chk("bp_stable", d0, 8'hA5);
        out_ready = 1'b1;
        step();
        chk("bp_second", d0, 8'h3C);
        chk("bp_ready_back", rdy0, 1);
        out_ready = 1'b0;
        idle();
        out_ready = 1'b1;
        idle();
        idle();

        // reset mid-word discards partial bits
        for (int i = 0; i < 5; i++) send(1, 0);
        rst      = 1'b1;
        in_valid = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", ov0, 0);
        send(0, 0); send(1, 0); send(0, 0); send(1, 0);
        send(0, 0); send(1, 0); send(0, 0); send(1, 0);
        chk("after_rst_data", d0, 8'hAA);
        chk("after_rst_count", c0, 8);
        idle();

        // sustained throughput
        vpos.delete();
        for (int i = 0; i < 32; i++) send(int'($urandom_range(0, 1)), 0);
        idle();
        idle();
        chk("tp_pulses", vpos.size(), 4);
        for (int i = 1; i < vpos.size(); i++)
            chk("tp_gap", vpos[i] - vpos[i-1], 8);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_bit    = 1'($urandom_range(0, 1));
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
